// File: rtl/issue_select.sv
// Issue select: picks one requesting slot by priority with round-robin tie-break,
// registers its payload for register-read and broadcasts RD for wakeup.
// Optional starvation override enabled by ISSUE_SELECT_STARVE_EN.
module issue_select #(
   parameter int NUM_SLOTS    = 8,
   parameter int WIDTH_REG    = 5,
   parameter int WIDTH_TAG    = 5,
   parameter int WIDTH_BRM    = 3,
   parameter int WIDTH_PRY    = 2,
   parameter int WIDTH_RSLOT  = WIDTH_BRM + WIDTH_TAG + 2 + 3*WIDTH_REG,
   parameter int STARVE_LIMIT = 15
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic [NUM_SLOTS-1:0]           i_request,
   input  logic [NUM_SLOTS*WIDTH_PRY-1:0] i_priority,
   input  logic [WIDTH_RSLOT-1:0]         i_rslot,
   input  logic [2**WIDTH_BRM-1:0]        i_brkill,
   input  logic                           i_stall,
   output logic [NUM_SLOTS-1:0]           o_grant,
   output logic                           o_valid,
   output logic [WIDTH_RSLOT-1:0]         o_uop,
   output logic [WIDTH_REG-1:0]           o_wdest
);
   localparam int RRW     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int BRM_LSB = WIDTH_TAG + 2 + 3*WIDTH_REG;

   logic                   valid_q, valid_d;
   logic [WIDTH_RSLOT-1:0] uop_q, uop_d;
   logic [RRW-1:0]         rr_q, rr_d;

   logic                   adv, found, gnt_en, kill_in, kill_uop;
   logic [RRW-1:0]         gidx, idx;
   logic [WIDTH_PRY-1:0]   maxp;
   logic [NUM_SLOTS-1:0]   cand, starve;

   assign adv      = ~valid_q | ~i_stall;
   assign kill_in  = i_brkill[i_rslot[BRM_LSB +: WIDTH_BRM]];
   assign kill_uop = i_brkill[uop_q[BRM_LSB +: WIDTH_BRM]];

`ifdef ISSUE_SELECT_STARVE_EN
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   logic [NUM_SLOTS-1:0][CW-1:0] cnt_q;

   // Counters only age while the select stage could have granted.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         for (int k = 0; k < NUM_SLOTS; k++) begin
            if (!i_request[k] || o_grant[k])
               cnt_q[k] <= '0;
            else if (adv && cnt_q[k] != CW'(STARVE_LIMIT))
               cnt_q[k] <= cnt_q[k] + 1'b1;
         end
      end
   end

   always_comb begin
      starve = '0;
      for (int k = 0; k < NUM_SLOTS; k++)
         starve[k] = i_request[k] && (cnt_q[k] == CW'(STARVE_LIMIT));
   end
`else
   assign starve = '0;
`endif

   always_comb begin
      maxp  = '0;
      cand  = '0;
      found = 1'b0;
      gidx  = '0;
      idx   = '0;
      for (int k = 0; k < NUM_SLOTS; k++)
         if (i_request[k] && i_priority[k*WIDTH_PRY +: WIDTH_PRY] > maxp)
            maxp = i_priority[k*WIDTH_PRY +: WIDTH_PRY];
      for (int k = 0; k < NUM_SLOTS; k++)
         cand[k] = i_request[k] && (i_priority[k*WIDTH_PRY +: WIDTH_PRY] == maxp);
      if (|starve)
         cand = starve;
      // Scan from rr upward; the pointer width makes the index wrap for free.
      for (int i = 0; i < NUM_SLOTS; i++) begin
         idx = rr_q + RRW'(i);
         if (!found && cand[idx]) begin
            found = 1'b1;
            gidx  = idx;
         end
      end
   end

   assign gnt_en  = adv & found & ~i_rst;
   assign o_grant = gnt_en ? (NUM_SLOTS'(1) << gidx) : '0;

   always_comb begin
      valid_d = valid_q;
      uop_d   = uop_q;
      rr_d    = rr_q;
      if (gnt_en) begin
         uop_d   = i_rslot;
         valid_d = ~kill_in;
         rr_d    = gidx + RRW'(1);
      end else if (valid_q && kill_uop) begin
         valid_d = 1'b0;
      end else if (adv) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q <= 1'b0;
         uop_q   <= '0;
         rr_q    <= '0;
      end else begin
         valid_q <= valid_d;
         uop_q   <= uop_d;
         rr_q    <= rr_d;
      end
   end

   assign o_valid = valid_q;
   assign o_uop   = uop_q;
   assign o_wdest = valid_q ? uop_q[2*WIDTH_REG +: WIDTH_REG] : '0;
endmodule

// File: tb/tb_issue_select.sv
// Bench for issue_select: directed scenarios plus randomized traffic checked
// against a cycle-level reference model of the select/issue rules.
module tb_issue_select;
   localparam int N = 8, WR = 5, WT = 5, WB = 3, WP = 2, LIM = 15;
   localparam int WRS = WB + WT + 2 + 3*WR;
   localparam int BRL = WT + 2 + 3*WR;

   logic                clk = 1'b0;
   logic                rst;
   logic [N-1:0]        req;
   logic [N-1:0][WP-1:0] pri;
   logic [N*WP-1:0]     pri_flat;
   logic [WRS-1:0]      rslot;
   logic [7:0]          brkill;
   logic                stall;
   logic [N-1:0]        grant;
   logic                valid;
   logic [WRS-1:0]      uop;
   logic [WR-1:0]       wdest;

   assign pri_flat = pri;
   always #5 clk = ~clk;

   issue_select dut (
      .i_clk(clk), .i_rst(rst), .i_request(req), .i_priority(pri_flat),
      .i_rslot(rslot), .i_brkill(brkill), .i_stall(stall),
      .o_grant(grant), .o_valid(valid), .o_uop(uop), .o_wdest(wdest)
   );

   int n_cmp = 0, n_err = 0;

   // Reference model state
   int             m_rr;
   bit             m_valid;
   logic [WRS-1:0] m_uop;
   int             m_cnt [N];

   function automatic int bmf(logic [WRS-1:0] m);
      return int'(m[BRL +: WB]);
   endfunction

   function automatic logic [N-1:0] onehot(int g);
      logic [N-1:0] v;
      v = '0;
      if (g >= 0) v[g] = 1'b1;
      return v;
   endfunction

   function automatic logic [WRS-1:0] payload(int bm, int rd);
      logic [WRS-1:0] p;
      p = WRS'($urandom);
      p[BRL +: WB] = WB'(bm);
      p[2*WR +: WR] = WR'(rd);
      return p;
   endfunction

   function automatic int exp_g();
      int  maxp;
      bit  any_st;
      maxp   = -1;
      any_st = 0;
      if (rst || (m_valid && stall) || req == '0) return -1;
`ifdef ISSUE_SELECT_STARVE_EN
      for (int k = 0; k < N; k++) if (req[k] && m_cnt[k] >= LIM) any_st = 1;
`endif
      for (int k = 0; k < N; k++) if (req[k] && int'(pri[k]) > maxp) maxp = int'(pri[k]);
      for (int i = 0; i < N; i++) begin
         int k;
         k = (m_rr + i) % N;
         if (any_st ? (req[k] && m_cnt[k] >= LIM) : (req[k] && int'(pri[k]) == maxp))
            return k;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_rr = 0; m_valid = 0; m_uop = '0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
   endtask

   // Advance one clock; model updated from pre-edge inputs, returns at negedge.
   task automatic tick();
      int g;
      bit adv;
      g   = exp_g();
      adv = !m_valid || !stall;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (g >= 0) begin
            m_uop = rslot; m_valid = !brkill[bmf(rslot)]; m_rr = (g + 1) % N;
         end else if (m_valid && brkill[bmf(m_uop)]) m_valid = 0;
         else if (adv) m_valid = 0;
         for (int k = 0; k < N; k++) begin
            if (k == g || !req[k]) m_cnt[k] = 0;
            else if (adv && m_cnt[k] < LIM) m_cnt[k]++;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; model_reset(); tick(); rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; pri = '0; rslot = '0; brkill = '0; stall = 1'b0;
      model_reset();
      @(negedge clk); #1;
      n_cmp++; if (grant !== '0) begin n_err++; $display("FAIL reset_grant: got %b want 0", grant); end
      n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
      n_cmp++; if (uop !== '0) begin n_err++; $display("FAIL reset_uop: got %h want 0", uop); end
      req = '1; #1;
      n_cmp++; if (grant !== '0) begin n_err++; $display("FAIL reset_grant_req: got %b want 0", grant); end
      tick(); rst = 1'b0; req = '0; tick();
   endtask

   task automatic test_priority();
      logic [WRS-1:0] p;
      req = 8'b0000_0110; pri = '0; pri[1] = 2'd1; pri[2] = 2'd3;
      p = payload(0, 7); rslot = p; #1;
      n_cmp++; if (grant !== 8'b0000_0100) begin n_err++; $display("FAIL prio_grant: got %b want 00000100", grant); end
      tick(); req = '0; #1;
      n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL prio_valid: got %b want 1", valid); end
      n_cmp++; if (uop !== p) begin n_err++; $display("FAIL prio_uop: got %h want %h", uop, p); end
      n_cmp++; if (wdest !== 5'd7) begin n_err++; $display("FAIL prio_wdest: got %0d want 7", wdest); end
      req = '1; pri = '0; #1;
      n_cmp++; if (grant !== 8'b0000_1000) begin n_err++; $display("FAIL prio_rr3: got %b want 00001000", grant); end
      tick(); req = '0; tick();
   endtask

   task automatic test_round_robin();
      do_reset();
      req = '1; pri = '0; stall = 1'b0;
      for (int i = 0; i < 9; i++) begin
         rslot = payload(0, i + 1); #1;
         n_cmp++;
         if (grant !== onehot(i % N)) begin
            n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", i, grant, onehot(i % N));
         end
         tick();
      end
      req = '0; tick();
   endtask

   task automatic test_backpressure();
      logic [WRS-1:0] held;
      stall = 1'b0; brkill = '0; req = 8'b0000_0001; pri = '0;
      held = payload(0, 9); rslot = held; tick();
      stall = 1'b1; req = 8'b0101_0000;
      for (int i = 0; i < 3; i++) begin
         rslot = payload(0, 4); #1;
         n_cmp++; if (grant !== '0) begin n_err++; $display("FAIL bp_grant[%0d]: got %b want 0", i, grant); end
         n_cmp++; if (uop !== held || valid !== 1'b1) begin
            n_err++; $display("FAIL bp_hold[%0d]: got %h/%b want %h/1", i, uop, valid, held);
         end
         tick();
      end
      stall = 1'b0; #1;
      n_cmp++; if (grant !== 8'b0001_0000) begin n_err++; $display("FAIL bp_release: got %b want 00010000", grant); end
      tick(); req = '0; tick();
   endtask

   task automatic test_kill();
      stall = 1'b0; brkill = '0; req = 8'b1000_0000; rslot = payload(3, 12); tick();
      stall = 1'b1; req = 8'b0000_0001; brkill = 8'b0000_1000; #1;
      n_cmp++; if (grant !== '0) begin n_err++; $display("FAIL kill_stalled_grant: got %b want 0", grant); end
      tick(); brkill = '0; rslot = payload(0, 1); #1;
      n_cmp++; if (valid !== 1'b0 || wdest !== '0) begin
         n_err++; $display("FAIL kill_held: got valid %b wdest %0d want 0/0", valid, wdest);
      end
      n_cmp++; if (grant !== 8'b0000_0001) begin n_err++; $display("FAIL kill_free: got %b want 00000001", grant); end
      tick();
      stall = 1'b0; req = 8'b0010_0000; rslot = payload(3, 13); brkill = 8'b0000_1000; #1;
      n_cmp++; if (grant !== 8'b0010_0000) begin n_err++; $display("FAIL kill_in_grant: got %b want 00100000", grant); end
      tick(); brkill = '0; req = '1; pri = '0; #1;
      n_cmp++; if (valid !== 1'b0 || wdest !== '0) begin
         n_err++; $display("FAIL kill_in: got valid %b wdest %0d want 0/0", valid, wdest);
      end
      n_cmp++; if (grant !== 8'b0100_0000) begin n_err++; $display("FAIL kill_rr: got %b want 01000000", grant); end
      tick(); req = '0; tick();
   endtask

   task automatic test_reset_mid();
      stall = 1'b0; req = '1;
      for (int i = 0; i < 3; i++) begin pri = 16'($urandom); rslot = payload(0, 5); tick(); end
      rst = 1'b1; model_reset(); #1;
      n_cmp++; if (valid !== 1'b0 || grant !== '0 || uop !== '0) begin
         n_err++; $display("FAIL rstmid_clear: got valid %b grant %b uop %h want 0", valid, grant, uop);
      end
      tick(); rst = 1'b0;
      req = 8'b1010_0100; pri = '0; pri[2] = 2'd1; pri[5] = 2'd2; pri[7] = 2'd2; #1;
      n_cmp++; if (grant !== 8'b0010_0000) begin n_err++; $display("FAIL rstmid_first: got %b want 00100000", grant); end
      tick(); req = '0; tick();
   endtask

   task automatic test_starve();
      int first, want;
      do_reset();
      first = -1; stall = 1'b0; brkill = '0; req = 8'b0000_0011; pri = '0; pri[1] = 2'd3;
      for (int c = 1; c <= 20; c++) begin
         rslot = payload(0, 2); #1;
         if (grant[0] && first < 0) first = c;
         n_cmp++; if (grant !== onehot(exp_g())) begin
            n_err++; $display("FAIL starve_grant[%0d]: got %b want %b", c, grant, onehot(exp_g()));
         end
         tick();
      end
`ifdef ISSUE_SELECT_STARVE_EN
      want = LIM + 1;
`else
      want = -1;
`endif
      n_cmp++; if (first != want) begin n_err++; $display("FAIL starve_cycle: got %0d want %0d", first, want); end
      req = '0; tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         if (rst) model_reset();
         req    = 8'($urandom);
         pri    = 16'($urandom);
         rslot  = WRS'($urandom);
         brkill = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         stall  = ($urandom_range(0, 2) == 0);
         #1;
         n_cmp++; if (grant !== onehot(exp_g())) begin
            n_err++; $display("FAIL rnd_grant[%0d]: got %b want %b", c, grant, onehot(exp_g()));
         end
         n_cmp++; if (valid !== m_valid) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, valid, m_valid); end
         n_cmp++; if (uop !== m_uop) begin n_err++; $display("FAIL rnd_uop[%0d]: got %h want %h", c, uop, m_uop); end
         n_cmp++; if (wdest !== (m_valid ? m_uop[2*WR +: WR] : 5'd0)) begin
            n_err++; $display("FAIL rnd_wdest[%0d]: got %0d want %0d", c, wdest, m_valid ? m_uop[2*WR +: WR] : 5'd0);
         end
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_priority();
      test_round_robin();
      test_backpressure();
      test_kill();
      test_reset_mid();
      test_starve();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
